// File: rtl/fpu8_issue_ctrl_if.sv
// Request / FPU / response bundle for fpu8_issue_ctrl.
// The slave modport is the controller's view; the master modport is the
// environment's view (request source, FPU and response sink).
interface fpu8_issue_ctrl_if;
    // Request channel
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] REQ_A;
    logic [7:0] REQ_B;
    logic [1:0] REQ_OP;
    logic       REQ_RND;
    // FPU drive
    logic       FP_Start;
    logic [7:0] OP_A;
    logic [7:0] OP_B;
    logic [1:0] FP_OPERATION;
    logic       FP_ROUND_MODE;
    // FPU return
    logic [7:0] OP_RESULT;
    logic       OP_IS_EXCEPTION;
    logic [2:0] FP_Exception;
    // Response channel
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_RESULT;
    logic       RSP_EXC;
    logic [2:0] RSP_EXC_CODE;
    logic [7:0] EXC_COUNT;

    modport slave (
        input  REQ_VALID, REQ_A, REQ_B, REQ_OP, REQ_RND,
        input  OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        input  RSP_READY,
        output REQ_READY,
        output FP_Start, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE,
        output RSP_VALID, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, EXC_COUNT
    );

    modport master (
        output REQ_VALID, REQ_A, REQ_B, REQ_OP, REQ_RND,
        output OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        output RSP_READY,
        input  REQ_READY,
        input  FP_Start, OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE,
        input  RSP_VALID, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, EXC_COUNT
    );
endinterface

// File: rtl/fpu8_issue_ctrl.sv
// fpu8_issue_ctrl: issues one operation at a time to an 8-bit FPU, waits
// RESULT_WAIT settle cycles, captures the result and holds it on a
// valid/ready response channel. A new request may be accepted on the same
// edge that retires the previous response.
// Optional feature: define FPU8_EXC_COUNT_EN to enable the saturating
// exception counter on EXC_COUNT; otherwise EXC_COUNT is tied to 0.
module fpu8_issue_ctrl #(
    parameter int unsigned RESULT_WAIT = 1
) (
    input  logic              FP_CLK,
    input  logic              FP_RST_N,
    fpu8_issue_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Settle-counter reload value; zero-wait builds skip WAIT entirely.
    localparam bit         ZERO_WAIT = (RESULT_WAIT == 0);
    localparam logic [3:0] WAIT_LOAD = ZERO_WAIT ? 4'd0 : 4'(RESULT_WAIT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] cnt_r;
    logic [3:0] cnt_nxt_s;
    logic       req_ready_s;
    logic       accept_s;
    logic       capture_s;

    logic       fp_start_r;
    logic       rsp_valid_r;
    logic [7:0] op_a_r;
    logic [7:0] op_b_r;
    logic [1:0] op_code_r;
    logic       op_rnd_r;
    logic [7:0] rsp_result_r;
    logic       rsp_exc_r;
    logic [2:0] rsp_exc_code_r;

    // Ready is combinational so a response and a new request can hand off on one edge.
    always_comb begin
        req_ready_s = 1'b0;
        if (!FP_RST_N) begin
            req_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            req_ready_s = 1'b1;
        end else if (state_r == ST_RESP) begin
            req_ready_s = bus.RSP_READY;
        end else begin
            req_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.REQ_VALID & req_ready_s;

    // Next-state, settle counter and capture decision.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ZERO_WAIT) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s   = WAIT_LOAD;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.RSP_READY && accept_s) begin
                    state_nxt_s = ST_ISSUE;
                end else if (bus.RSP_READY) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, strobes, operand latch and result capture registers.
    always_ff @(posedge FP_CLK) begin
        if (!FP_RST_N) begin
            state_r        <= ST_IDLE;
            cnt_r          <= 4'd0;
            fp_start_r     <= 1'b0;
            rsp_valid_r    <= 1'b0;
            op_a_r         <= 8'd0;
            op_b_r         <= 8'd0;
            op_code_r      <= 2'd0;
            op_rnd_r       <= 1'b0;
            rsp_result_r   <= 8'd0;
            rsp_exc_r      <= 1'b0;
            rsp_exc_code_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            fp_start_r  <= (state_nxt_s == ST_ISSUE);
            rsp_valid_r <= (state_nxt_s == ST_RESP);
            if (accept_s) begin
                op_a_r    <= bus.REQ_A;
                op_b_r    <= bus.REQ_B;
                op_code_r <= bus.REQ_OP;
                op_rnd_r  <= bus.REQ_RND;
            end
            if (capture_s) begin
                rsp_result_r   <= bus.OP_RESULT;
                rsp_exc_r      <= bus.OP_IS_EXCEPTION;
                rsp_exc_code_r <= bus.FP_Exception;
            end
        end
    end

`ifdef FPU8_EXC_COUNT_EN
    // Saturating 8-bit increment.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

    logic [7:0] exc_cnt_r;

    // Count captured exception results, sticking at 255.
    always_ff @(posedge FP_CLK) begin
        if (!FP_RST_N) begin
            exc_cnt_r <= 8'd0;
        end else if (capture_s && bus.OP_IS_EXCEPTION) begin
            exc_cnt_r <= sat_inc8(exc_cnt_r);
        end
    end

    assign bus.EXC_COUNT = exc_cnt_r;
`else
    assign bus.EXC_COUNT = 8'd0;
`endif

    assign bus.REQ_READY     = req_ready_s;
    assign bus.FP_Start      = fp_start_r;
    assign bus.OP_A          = op_a_r;
    assign bus.OP_B          = op_b_r;
    assign bus.FP_OPERATION  = op_code_r;
    assign bus.FP_ROUND_MODE = op_rnd_r;
    assign bus.RSP_VALID     = rsp_valid_r;
    assign bus.RSP_RESULT    = rsp_result_r;
    assign bus.RSP_EXC       = rsp_exc_r;
    assign bus.RSP_EXC_CODE  = rsp_exc_code_r;

endmodule

// File: doc/fpu8_issue_ctrl.md
FPU8_ISSUE_CTRL -- requirements
Module: fpu8_issue_ctrl

Interface
REQ-001 Parameter RESULT_WAIT, default 1, SHALL set the number of settle cycles (0..15) between FP_Start and result capture.
REQ-002 FP_CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 FP_RST_N  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 REQ_VALID  input  1  SHALL flag a pending operation request.
REQ-005 REQ_READY  output  1  SHALL flag that the block accepts a request this cycle.
REQ-006 REQ_A, REQ_B  input  8 each  SHALL carry the request operands.
REQ-007 REQ_OP  input  2  SHALL carry the request operation code; REQ_RND  input  1  SHALL carry the request rounding mode.
REQ-008 FP_Start  output  1  SHALL be the one-cycle start strobe to the FPU.
REQ-009 OP_A, OP_B  output  8 each; FP_OPERATION  output  2; FP_ROUND_MODE  output  1: these SHALL carry the FPU operand and control drive.
REQ-010 OP_RESULT  input  8; OP_IS_EXCEPTION  input  1; FP_Exception  input  3: these SHALL carry the FPU result and exception return.
REQ-011 RSP_VALID  output  1; RSP_READY  input  1: these SHALL form the response handshake.
REQ-012 RSP_RESULT  output  8; RSP_EXC  output  1; RSP_EXC_CODE  output  3: these SHALL hold the captured result, exception flag and exception code.
REQ-013 EXC_COUNT  output  8  SHALL report the exception count (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-015 A request SHALL be accepted on a rising edge where REQ_VALID and REQ_READY are both 1.
- REQ_A, REQ_B, REQ_OP and REQ_RND are latched into OP_A, OP_B, FP_OPERATION and FP_ROUND_MODE.
- The FSM moves to ISSUE.
REQ-016 REQ_READY SHALL be 1 in IDLE, and in RESP when RSP_READY=1; it SHALL be 0 otherwise.
REQ-017 In ISSUE, FP_Start SHALL be 1 for exactly one cycle.
- The next state is WAIT with the counter loaded to RESULT_WAIT-1.
- When RESULT_WAIT=0, the next state is RESP, with capture on the ISSUE-exit edge.
REQ-018 In WAIT, the counter SHALL decrement each cycle. On the edge where the counter equals 0:
- OP_RESULT, OP_IS_EXCEPTION and FP_Exception are captured into RSP_RESULT, RSP_EXC and RSP_EXC_CODE.
- The FSM moves to RESP.
REQ-019 OP_A, OP_B, FP_OPERATION and FP_ROUND_MODE SHALL stay stable from ISSUE through the capture edge, and SHALL hold their values until the next acceptance.
REQ-020 In RESP, RSP_VALID SHALL be 1, and RSP_RESULT, RSP_EXC and RSP_EXC_CODE SHALL be stable until RSP_READY=1.
REQ-021 When RSP_READY=1 in RESP and REQ_VALID=0, the next state SHALL be IDLE.
REQ-022 When RSP_READY=1 and REQ_VALID=1 in RESP, the response and the new request SHALL complete on the same edge and the next state SHALL be ISSUE.
REQ-023 Latency: with acceptance at edge E, FP_Start SHALL be high in cycle E+1 and RSP_VALID SHALL first be high in cycle E+2+RESULT_WAIT.
REQ-024 REQ_VALID during ISSUE or WAIT SHALL be ignored, with no side effects.
REQ-025 FP_Start SHALL never be asserted in any state other than ISSUE.

Reset
REQ-026 FP_RST_N=0 at a rising edge SHALL force the following, from any state including mid-WAIT:
- FSM state IDLE.
- FP_Start=0 and RSP_VALID=0.
- OP_A, OP_B, FP_OPERATION, FP_ROUND_MODE, RSP_RESULT, RSP_EXC, RSP_EXC_CODE, EXC_COUNT and the counter all 0.
REQ-027 REQ_READY SHALL be 0 while FP_RST_N=0, and 1 on the first cycle after release.
REQ-028 An operation in flight when reset is asserted SHALL be discarded and no response issued.

Configuration
REQ-029 With macro FPU8_EXC_COUNT_EN defined, EXC_COUNT SHALL increment by 1 at each capture edge where OP_IS_EXCEPTION=1, saturating at 255.
REQ-030 With FPU8_EXC_COUNT_EN undefined, EXC_COUNT SHALL be the constant 0 and no counter register SHALL exist.

Verification
REQ-031 The bench SHALL cover: RESULT_WAIT=1, request A=8'h3C, B=8'h40, OP=2'b00, FPU model returning 8'h44/no exception -> FP_Start high exactly one cycle, RSP_VALID rises 3 cycles after acceptance with RSP_RESULT=8'h44, RSP_EXC=0.
REQ-032 The bench SHALL cover: RSP_READY held 0 for 5 cycles -> RSP_VALID and RSP_RESULT stable, REQ_READY=0, and changing OP_RESULT has no effect on RSP_RESULT.
REQ-033 The bench SHALL cover: RSP_READY=1 and REQ_VALID=1 in the same RESP cycle -> next cycle is ISSUE with FP_Start=1 and the new operands on OP_A/OP_B.
REQ-034 The bench SHALL cover: FP_RST_N=0 during WAIT -> next cycle IDLE, RSP_VALID=0, no response ever issued for the aborted operation.
REQ-035 The bench SHALL cover: RESULT_WAIT=0 with FPU model returning OP_IS_EXCEPTION=1, FP_Exception=3'b101 -> RSP_VALID 2 cycles after acceptance, RSP_EXC=1, RSP_EXC_CODE=3'b101.
REQ-036 The bench SHALL cover, with FPU8_EXC_COUNT_EN defined: 300 exception results -> EXC_COUNT=255; and with the macro undefined -> EXC_COUNT=0.
